// File: rtl/icache_axi_rd_bridge.sv
// icache_axi_rd_bridge: services one ICache line fill at a time by issuing a
// single 4-beat AXI4 INCR read burst and returning the assembled 128-bit line.
module icache_axi_rd_bridge #(
    parameter logic [3:0]  AXI_ID     = 4'd0,
    // Only 4 is supported: the line buffer and beat counter are sized for it.
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         resetn,

    // Cache refill request / return
    input  logic         rd_req,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [127:0] ret_data,
    output logic         ret_err,

    // AXI4 read address channel
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,

    // AXI4 read data channel
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAr   = 2'd1;
    localparam logic [1:0] StR    = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [31:0]  addr_q;
    logic [1:0]   cnt_q;
    logic         err_q;
    logic [127:0] line_q;
    logic         accept;
    logic         beat;

    // RID is not checked and the low address bits are forced to zero.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rd_addr[3:0]};

    assign accept = (state_q == StIdle) && rd_req;
    assign beat   = (state_q == StR) && rvalid;

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (rd_req)         state_d = StAr;
            StAr:   if (arready)        state_d = StR;
            StR:    if (rvalid && rlast) state_d = StDone;
            StDone:                     state_d = StIdle;
            default:                    state_d = StIdle;
        endcase
    end

    // State, request latch, beat counter, error flag and line buffer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            addr_q  <= 32'd0;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
            line_q  <= 128'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= {rd_addr[31:4], 4'h0};
                cnt_q  <= 2'd0;
                err_q  <= 1'b0;
            end
            if (beat) begin
                // Extra beats of an over-long burst keep landing in word 3.
                line_q[{cnt_q, 5'b0} +: 32] <= rdata;
                if (cnt_q != 2'd3) begin
                    cnt_q <= cnt_q + 2'd1;
                end
                err_q <= err_q | (rresp != 2'b00);
            end
        end
    end

    // Outputs are decoded from state only; rd_rdy is also gated by reset.
    always_comb begin
        rd_rdy    = (state_q == StIdle) && resetn;
        arvalid   = (state_q == StAr);
        rready    = (state_q == StR);
        ret_valid = (state_q == StDone);
        ret_err   = (state_q == StDone) && err_q;
        ret_data  = line_q;
        arid      = AXI_ID;
        araddr    = addr_q;
        arlen     = 8'(LINE_WORDS - 1);
        arsize    = 3'b010;
        arburst   = 2'b01;
    end

endmodule

// File: doc/icache_axi_rd_bridge.md
# icache_axi_rd_bridge

- Read-side responder for the instruction cache's refill port.
- Accepts one line-fill request (`rd_req`/`rd_addr`), issues a single AXI4 INCR read burst of 4×32-bit beats, and assembles the beats into a 128-bit line.
- Returns the line to the cache as a one-cycle `ret_valid` pulse.
- Sits between the ICache MISS/REFILL state machine and the core's AXI read channel; one request in flight at a time.

## Interface
Parameters:
- `AXI_ID`, 4'd0: constant ARID for all bursts; RID is not checked.
- `LINE_WORDS`, 4: beats per line; ARLEN = `LINE_WORDS`-1. Only 4 is supported.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `rd_req` in 1: cache requests a line fill.
- `rd_addr` in 32: physical line address; bits [3:0] are ignored and forced to 0.
- `rd_rdy` out 1: bridge can accept a request this cycle.
- `ret_valid` out 1: one-cycle pulse; `ret_data` holds the full line.
- `ret_data` out 128: word k (byte offset 4k) in bits [32k+31:32k].
- `ret_err` out 1: valid with `ret_valid`; 1 if any beat had RRESP≠OKAY.
- `arid` out 4; `araddr` out 32; `arlen` out 8; `arsize` out 3; `arburst` out 2.
- `arvalid` out 1; `arready` in 1.
- `rid` in 4; `rdata` in 32; `rresp` in 2; `rlast` in 1; `rvalid` in 1; `rready` out 1.

## Operation
State machine: IDLE, AR, R, DONE.
- **IDLE**
  - `rd_rdy`=1.
  - On `rd_req`=1: latch {`rd_addr`[31:4],4'b0} into `addr_q`, clear the beat counter, clear the error flag, go to AR.
- **AR**
  - `arvalid`=1, `araddr`=`addr_q`, `arlen`=8'd3, `arsize`=3'b010, `arburst`=2'b01, `arid`=`AXI_ID`.
  - Hold all AR fields stable until `arready`, then go to R.
- **R**
  - `rready`=1.
  - On each `rvalid`: write `rdata` into line word[cnt]; cnt increments and saturates at 3 (extra beats overwrite word 3).
  - On each `rvalid`: error flag |= (`rresp`≠0).
  - On `rvalid` with `rlast`=1: go to DONE. A short burst leaves the unwritten words at their previous value.
- **DONE**
  - `ret_valid`=1 for exactly this cycle, `ret_err`=error flag; next state IDLE.
- `rd_rdy`=0 in AR, R and DONE. `rd_req` is ignored outside IDLE; the cache holds `rd_req` until it sees `rd_rdy`.
- `ret_data` is a registered line buffer. It holds its value after DONE until the next beat is written, and is not cleared between requests.
- AR fields outside AR are don't-care but driven from `addr_q` (no X).
- No abort/flush input: a started burst always completes.

## Timing
- Reset (`resetn`=0 at a posedge):
  - State goes to IDLE, cnt=0, line buffer=0, `ret_valid`=0, `ret_err`=0, `arvalid`=0, `rready`=0.
  - `rd_rdy` is forced to 0 while `resetn`=0 and becomes 1 in the first cycle after reset deasserts.
- Reset mid-burst abandons the transaction. Any remaining R beats are not accepted (`rready`=0 until the next burst). Reset is only used system-wide, so the slave is reset too.
- Request accept: cycle 0, IDLE with `rd_req`=1. Then `arvalid`=1 from cycle 1.
- Minimum latency, with `arready`=1 in cycle 1 and `rvalid` continuous with rlast on the 4th beat:
  - Beats accepted in cycles 2–5.
  - `ret_valid` in cycle 6.
  - `rd_rdy`=1 again in cycle 7.
- Each cycle of `arready`=0 adds one cycle; each `rvalid`=0 gap in R adds one cycle.
- Beats are stored on the posedge where `rvalid`&&`rready`. All outputs except `rd_rdy` are registered or decoded from state only, with no combinational path from AXI inputs.
- Back-to-back: a `rd_req` held during DONE is accepted in the following IDLE cycle. Maximum throughput is one line per 7 cycles.

## Test plan
1. **Single fill, ideal slave.**
   - Stimulus: reset, then `rd_req` with `rd_addr`=0x1FC0_0014, `arready`=1, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 (rlast on the 4th).
   - Required: `araddr`=0x1FC0_0010, `arlen`=3, `arsize`=2, `arburst`=1.
   - Required: `ret_valid` pulses in cycle 6 with `ret_data`=0x44444444_33333333_22222222_11111111 and `ret_err`=0.
2. **Back-pressure.**
   - Stimulus: `arready` low for 3 cycles; `rvalid` gaps of 2 cycles between beats.
   - Required: AR fields stable while `arvalid`=1 and `arready`=0.
   - Required: correct line; `ret_valid` in cycle 6+3+6=15.
3. **Error response.**
   - Stimulus: beat 2 returns `rresp`=2'b10.
   - Required: full line is still returned; `ret_err`=1 with `ret_valid`.
   - Required: the next clean request returns `ret_err`=0.
4. **Busy / back-to-back.**
   - Stimulus: `rd_req` held continuously with a new address during R.
   - Required: `rd_rdy`=0 and no second AR during the burst.
   - Required: the second request is accepted the cycle after `ret_valid`, with `araddr` equal to the second address.
5. **Reset mid-burst.**
   - Stimulus: assert `resetn`=0 after 2 beats.
   - Required: the next cycle shows `arvalid`=0, `rready`=0, `ret_valid`=0, `rd_rdy`=0.
   - Required: after deassert, `rd_rdy`=1 and a fresh request completes correctly.
6. **Malformed burst.**
   - Stimulus: `rlast` on beat 2 (short burst).
   - Required: DONE follows immediately; words 0–1 are new, words 2–3 keep their previous values.
   - Stimulus: 6 beats with `rlast` on the 6th (long burst).
   - Required: word 3 equals the 6th beat's data.
